// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves a conditional branch in the execute stage and maintains a
// direct-mapped table of 2-bit saturating counters that predicts branches
// for the fetch stage.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst_n            asynchronous active-low reset
//   pred_pc          fetch-stage PC to predict
//   pred_taken       prediction for pred_pc (bit 1 of its counter)
//   res_valid        a branch is being resolved this cycle
//   res_flush        the resolving branch is squashed
//   res_pc           PC of the resolving branch
//   res_funct3       branch condition code
//   res_pred_taken   prediction that was made for this branch at fetch
//   rdata1, rdata2   register-file operands
//   mem_fwd, wb_fwd  MEM / WB forwarding values
//   fwd_a, fwd_b     operand source selects (bit 1 = MEM, bit 0 = WB)
//   res_taken        branch outcome
//   res_mispredict   outcome differs from prediction
//   res_illegal      res_funct3 is not a branch code
//
// Optional feature: define BRANCH_STATS_EN to add two 32-bit counters,
// stat_branches and stat_mispredicts, that count table updates and the
// mispredicted subset of them.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_flush,
    input  logic [XLEN-1:0] res_pc,
    input  logic [2:0]      res_funct3,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_MAX   = 2'b11;
    localparam logic [1:0] CNT_MIN   = 2'b00;

    logic [1:0]      bht [BHT_DEPTH];
    logic [IDXW-1:0] pred_idx;
    logic [IDXW-1:0] res_idx;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            cond_true;
    logic            illegal_code;
    logic            res_active;
    logic            update_en;

    // Word-aligned PCs: bits [1:0] never vary, so the index starts at bit 2.
    // Upper PC bits are deliberately ignored (aliasing, no tag).
    assign pred_idx = pred_pc[IDXW+1:2];
    assign res_idx  = res_pc[IDXW+1:2];

    // Bits of the PCs that do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDXW+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDXW+2],  res_pc[1:0]};

    // Forwarding muxes: MEM is the younger producer, so it wins over WB.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/case can leave it unassigned (no latch).
        op_a = rdata1;
        op_b = rdata2;
        if (fwd_a[1])      op_a = mem_fwd;
        else if (fwd_a[0]) op_a = wb_fwd;
        if (fwd_b[1])      op_b = mem_fwd;
        else if (fwd_b[0]) op_b = wb_fwd;
    end

    // Branch condition evaluation.
    always_comb begin
        cond_true    = 1'b0;
        illegal_code = 1'b0;
        case (res_funct3)
            3'b000:  cond_true = (op_a == op_b);
            3'b001:  cond_true = (op_a != op_b);
            3'b100:  cond_true = ($signed(op_a) <  $signed(op_b));
            3'b101:  cond_true = ($signed(op_a) >= $signed(op_b));
            3'b110:  cond_true = (op_a <  op_b);
            3'b111:  cond_true = (op_a >= op_b);
            default: illegal_code = 1'b1;  // 010, 011
        endcase
    end

    assign res_active = res_valid & ~res_flush;

    // Outputs are quiet unless a live (non-flushed) branch is resolving;
    // an illegal code reports itself but never claims taken or mispredict.
    always_comb begin
        res_taken      = 1'b0;
        res_mispredict = 1'b0;
        res_illegal    = 1'b0;
        if (res_active) begin
            if (illegal_code) begin
                res_illegal = 1'b1;
            end else begin
                res_taken      = cond_true;
                res_mispredict = cond_true ^ res_pred_taken;
            end
        end
    end

    assign update_en = res_active & ~illegal_code;

    // Read is combinational from the current table contents, so a
    // same-cycle update to the same index is only seen after the edge.
    assign pred_taken = bht[pred_idx][1];

    // NOTE: the table is reset as a whole (not just the read path) because
    // every entry must read weakly-not-taken right after reset; this forces
    // flops rather than a RAM macro, which is acceptable at this depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                // NOTE: state is written with non-blocking assignments so
                // every flop samples pre-edge values, independent of order.
                bht[i] <= CNT_RESET;
            end
        end else if (update_en) begin
            if (cond_true) begin
                if (bht[res_idx] != CNT_MAX) bht[res_idx] <= bht[res_idx] + 2'd1;
            end else begin
                if (bht[res_idx] != CNT_MIN) bht[res_idx] <= bht[res_idx] - 2'd1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Statistics count exactly the resolves that train the table; they wrap
    // naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (update_en) begin
            stat_branches <= stat_branches + 32'd1;
            if (res_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
